lfsr_bcd_source: RTL and testbench
==================================

Name: lfsr_bcd_source

Overview:
- Upstream stage for the board's 7-segment decoders.
- Holds an 8-bit LFSR that advances one step per rising edge of the step button.
- Converts the new LFSR value to three BCD digits (hundreds/tens/ones) with a sequential shift-add-3 (double-dabble) engine.
- Presents stable digits, each 0–9, to three downstream BCD-to-7-segment decoders, plus the raw value for LEDs.

Parameters:
- SEED, 8'h01, LFSR reset value and reseed value; must be nonzero.
- TAPS, 8'b0001_1101, feedback tap mask; new bit = XOR of q bits where mask=1 (default q4^q3^q2^q0).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- step_btn  input  1  raw button, asynchronous to clk
- lfsr_q  output  8  current LFSR state
- bcd_hund  output  4  hundreds digit, 0–2
- bcd_tens  output  4  tens digit, 0–9
- bcd_ones  output  4  ones digit, 0–9
- busy  output  1  conversion in progress (CONV or DONE)
- valid  output  1  one-cycle pulse when the digits have just updated

Behaviour:
- Clocking: one clock, clk. Reset rst_n is asynchronous, active-low; it clears every flop immediately.
- Reset values: lfsr_q=SEED; digits = BCD of SEED (default 0,0,1); busy=0; valid=0; pending=0; state=IDLE; synchronizer flops=0.
- Input path: step_btn passes through a 2-flop synchronizer, then a rising-edge detector, giving a 1-cycle step_pulse.
  - Latency from a btn rise to step_pulse is 2–3 cycles.
  - A held button produces exactly one pulse.
- LFSR step: q_next = {fb, q[7:1]}, where fb = ^(q & TAPS). If q==0, q_next=SEED (lock-up escape).
- FSM states: IDLE, CONV, DONE.
- IDLE:
  - If step_pulse or pending: at the next edge, LFSR steps, the shift register loads the new value, pending clears, and the state goes to CONV with bit counter=0.
  - Otherwise remain in IDLE.
- CONV: 8 cycles. In each cycle:
  - Any BCD nibble ≥5 has 3 added to it.
  - Then the {bcd[11:0], bin[7:0]} register shifts left by 1.
  - After the 8th shift: the digit outputs register the result, the state goes to DONE, and valid=1 during the DONE cycle.
- DONE: one cycle, then IDLE; valid returns to 0.
- Total latency: from the accepting edge to the digit update is 9 edges; valid is high exactly one cycle.
- lfsr_q changes only at accept. Digits change only at the CONV→DONE edge and hold between updates, so the display never shows intermediate values.
- Steps while busy (a step_pulse in CONV or DONE): set pending. Pending is 1 deep; extra pulses are dropped.
- Simultaneous events: a step_pulse in the DONE cycle sets pending, which is accepted from IDLE on the following edge. A step_pulse in IDLE with pending already set counts as one step.
- Arithmetic: max value 255 gives 2,5,5. The add-3 is 4-bit and cannot overflow, because a nibble is ≤9 before the shift.
- Reset during CONV/DONE: conversion is aborted, outputs return to reset values, and no valid pulse is produced.

Decomposition:
- Package lfsr_bcd_pkg holds:
  - the state enum {IDLE, CONV, DONE};
  - constants LFSR_W=8, BCD_W=4, NDIGITS=3, CONV_CYCLES=8;
  - the default TAPS.
- One sub-module, bin8_to_bcd_seq, is natural. It holds the start/busy/done handshake, the shift register, the bit counter and the digit registers. The top level keeps the synchronizer, edge detect, LFSR and pending logic.

Test Plan:
- Reset: assert rst_n=0 mid-cycle → outputs immediately read lfsr_q=8'h01, digits 0/0/1, busy=0, valid=0.
- Single press from reset → lfsr_q=8'h80; 9 edges after accept, digits 1/2/8 with a one-cycle valid; busy high for 9 cycles.
- Five presses spaced 20 cycles apart → lfsr_q sequence 80, 40, 20, 10, 88; digits 128, 064, 032, 016, 136; next press → C4 / 196.
- Button held 50 cycles → exactly one step, one valid pulse.
- Three pulses during one CONV → exactly two total steps. Second conversion starts 1 cycle after returning to IDLE. Two valid pulses.
- rst_n low at CONV cycle 4 → no valid pulse; outputs at reset values; pending cleared. A press after release behaves as in the single-press scenario.

Source files
------------

// File: rtl/lfsr_bcd_pkg.sv
// Shared types, widths and helper arithmetic for the LFSR-to-BCD display source.
package lfsr_bcd_pkg;
    localparam int LFSR_W      = 8;
    localparam int BCD_W       = 4;
    localparam int NDIGITS     = 3;
    localparam int CONV_CYCLES = 8;
    localparam int SR_W        = NDIGITS * BCD_W + LFSR_W;

    localparam logic [LFSR_W-1:0] DEFAULT_TAPS = 8'b0001_1101;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    // One double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
    function automatic logic [SR_W-1:0] add3(input logic [SR_W-1:0] v);
        logic [SR_W-1:0] r;
        r = v;
        for (int d = 0; d < NDIGITS; d++) begin
            if (r[LFSR_W+BCD_W*d +: BCD_W] >= 4'd5) begin
                r[LFSR_W+BCD_W*d +: BCD_W] = r[LFSR_W+BCD_W*d +: BCD_W] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [NDIGITS*BCD_W-1:0] bin_to_bcd(input logic [LFSR_W-1:0] bin);
        logic [SR_W-1:0] sr;
        sr = {{(NDIGITS*BCD_W){1'b0}}, bin};
        for (int s = 0; s < CONV_CYCLES; s++) begin
            sr = add3(sr) << 1;
        end
        return sr[SR_W-1:LFSR_W];
    endfunction
endpackage

// File: rtl/lfsr_bcd_if.sv
// Button input and display/LED outputs of the LFSR BCD source.
interface lfsr_bcd_if;
    logic       step_btn;
    logic [7:0] lfsr_q;
    logic [3:0] bcd_hund;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       busy;
    logic       valid;

    modport master (
        input  step_btn,
        output lfsr_q, bcd_hund, bcd_tens, bcd_ones, busy, valid
    );

    modport slave (
        output step_btn,
        input  lfsr_q, bcd_hund, bcd_tens, bcd_ones, busy, valid
    );
endinterface

// File: rtl/bin8_to_bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per cycle.
//   state | meaning
//   IDLE  | waiting for start; digits hold last result
//   CONV  | add-3 and shift, CONV_CYCLES cycles
//   DONE  | digits just updated; done pulses for this cycle
module bin8_to_bcd_seq
    import lfsr_bcd_pkg::*;
#(
    parameter logic [LFSR_W-1:0] RST_VAL = DEFAULT_SEED
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LFSR_W-1:0]         din,
    output logic                      busy,
    output logic                      done,
    output logic [NDIGITS*BCD_W-1:0]  digits
);
    localparam logic [NDIGITS*BCD_W-1:0] RST_DIGITS = bin_to_bcd(RST_VAL);
    localparam logic [2:0]               LAST_BIT   = 3'(CONV_CYCLES - 1);

    state_t                     state_q, state_d;
    logic [SR_W-1:0]            sr_q, sr_d;
    logic [2:0]                 cnt_q, cnt_d;
    logic [NDIGITS*BCD_W-1:0]   dig_q, dig_d;
    logic [SR_W-1:0]            shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            dig_q   <= RST_DIGITS;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dig_q   <= dig_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dig_d   = dig_q;
        shifted = add3(sr_q) << 1;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = {{(NDIGITS*BCD_W){1'b0}}, din};
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sr_d  = shifted;
                cnt_d = cnt_q + 3'd1;
                if (cnt_q == LAST_BIT) begin
                    dig_d   = shifted[SR_W-1:LFSR_W];
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign digits = dig_q;
endmodule

// File: rtl/lfsr_bcd_source.sv
// Button-stepped 8-bit LFSR whose value is converted to stable BCD digits for 7-segment decoders.
module lfsr_bcd_source
    import lfsr_bcd_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
    input  logic      clk,
    input  logic      rst_n,
    lfsr_bcd_if.master io
);
    logic                     sync1_q, sync1_d;
    logic                     sync2_q, sync2_d;
    logic                     prev_q, prev_d;
    logic                     pending_q, pending_d;
    logic [LFSR_W-1:0]        lfsr_q, lfsr_d;
    logic [LFSR_W-1:0]        lfsr_next;
    logic                     step_pulse;
    logic                     accept;
    logic                     conv_busy;
    logic                     conv_done;
    logic [NDIGITS*BCD_W-1:0] digits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pending_q <= 1'b0;
            lfsr_q    <= SEED;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pending_q <= pending_d;
            lfsr_q    <= lfsr_d;
        end
    end

    always_comb begin
        sync1_d    = io.step_btn;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        step_pulse = sync2_q & ~prev_q;

        // An all-zero register would never leave zero, so it is reseeded.
        if (lfsr_q == '0) lfsr_next = SEED;
        else              lfsr_next = {^(lfsr_q & TAPS), lfsr_q[LFSR_W-1:1]};

        accept    = !conv_busy && (step_pulse || pending_q);
        lfsr_d    = accept ? lfsr_next : lfsr_q;
        pending_d = pending_q;
        if (accept)                       pending_d = 1'b0;
        else if (step_pulse && conv_busy) pending_d = 1'b1;
    end

    bin8_to_bcd_seq #(
        .RST_VAL (SEED)
    ) u_conv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept),
        .din    (lfsr_next),
        .busy   (conv_busy),
        .done   (conv_done),
        .digits (digits)
    );

    assign io.lfsr_q   = lfsr_q;
    assign io.bcd_hund = digits[11:8];
    assign io.bcd_tens = digits[7:4];
    assign io.bcd_ones = digits[3:0];
    assign io.busy     = conv_busy;
    assign io.valid    = conv_done;
endmodule

// File: tb/tb_lfsr_bcd_source.sv
// Scoreboard bench for lfsr_bcd_source: presses push expected {lfsr, digits}, a monitor checks each valid.
module tb_lfsr_bcd_source;
    logic clk;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   vcnt  = 0;
    int   idx   = 0;
    logic [19:0] exp_q[$];
    logic [11:0] last_dig;

    logic [7:0]  tbl_lfsr [7] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h88, 8'hC4, 8'hE2};
    logic [11:0] tbl_bcd  [7] = '{12'h128, 12'h064, 12'h032, 12'h016, 12'h136, 12'h196, 12'h226};

    lfsr_bcd_if bus ();

    lfsr_bcd_source dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic push_next();
        exp_q.push_back({tbl_lfsr[idx], tbl_bcd[idx]});
        idx++;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_lfsr"},   bus.lfsr_q, 8'h01);
        check({tag, "_digits"}, {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, 12'h001);
        check({tag, "_busy"},   bus.busy, 1'b0);
        check({tag, "_valid"},  bus.valid, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs(tag);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idx = 0;
    endtask

    task automatic press(input int hold);
        @(posedge clk);
        #2 bus.step_btn = 1'b1;
        repeat (hold) @(posedge clk);
        #2 bus.step_btn = 1'b0;
    endtask

    task automatic wait_valid(input string name, input int max_cyc);
        bit seen = 0;
        for (int c = 0; c < max_cyc && !seen; c++) begin
            @(negedge clk);
            if (bus.valid) seen = 1;
        end
        check({name, "_valid_seen"}, seen, 1'b1);
    endtask

    // Press once and measure busy length and accept-to-valid spacing.
    task automatic single_press_measure(input string name);
        int busy_cnt = 0;
        int first = -1;
        int vcyc = -1;
        push_next();
        @(posedge clk);
        #2 bus.step_btn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (c == 4) bus.step_btn = 1'b0;
            if (bus.busy) begin
                busy_cnt++;
                if (first < 0) first = c;
            end
            if (bus.valid && vcyc < 0) vcyc = c;
        end
        check({name, "_busy_cycles"}, busy_cnt, 9);
        check({name, "_valid_seen"}, (vcyc >= 0), 1'b1);
        check({name, "_latency"}, vcyc - first, 8);
    endtask

    // Monitor: compares every valid against the scoreboard, digits must hold otherwise.
    initial begin
        bit prev_valid = 0;
        last_dig = 12'h001;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_dig   = 12'h001;
                prev_valid = 0;
            end else if (bus.valid) begin
                logic [19:0] e;
                vcnt++;
                check("valid_single_cycle", prev_valid, 1'b0);
                check("valid_expected", (exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_lfsr", bus.lfsr_q, e[19:12]);
                    check("sb_digits", {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, e[11:0]);
                end
                last_dig   = {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones};
                prev_valid = 1;
            end else begin
                check("digits_hold", {bus.bcd_hund, bus.bcd_tens, bus.bcd_ones}, last_dig);
                prev_valid = 0;
            end
        end
    end

    initial begin
        int v0;
        bus.step_btn = 1'b0;
        rst_n = 1'b0;
        #23 check_reset_outputs("init_reset");
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Single press from reset
        single_press_measure("single");
        check("single_lfsr_hold", bus.lfsr_q, 8'h80);

        // Six spaced presses from reset
        do_reset("rst_seq");
        for (int i = 0; i < 6; i++) begin
            push_next();
            press(3);
            repeat (17) @(posedge clk);
        end
        check("seq_lfsr_final", bus.lfsr_q, 8'hC4);

        // Held button gives exactly one step
        v0 = vcnt;
        push_next();
        press(50);
        repeat (20) @(posedge clk);
        check("held_one_valid", vcnt - v0, 1);
        check("held_lfsr", bus.lfsr_q, 8'hE2);

        // Three pulses during one conversion -> two steps total
        do_reset("rst_burst");
        v0 = vcnt;
        push_next();
        push_next();
        press(1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            press(1);
        end
        wait_valid("burst_first", 40);
        @(negedge clk);
        check("burst_idle_gap", bus.busy, 1'b0);
        @(negedge clk);
        check("burst_restart", bus.busy, 1'b1);
        wait_valid("burst_second", 40);
        repeat (30) @(posedge clk);
        check("burst_two_valids", vcnt - v0, 2);
        check("burst_lfsr", bus.lfsr_q, 8'h40);

        // Reset in the middle of a conversion
        do_reset("rst_abort_pre");
        v0 = vcnt;
        push_next();
        press(1);
        press(4);
        begin
            bit b = 0;
            for (int c = 0; c < 10 && !b; c++) begin
                @(negedge clk);
                if (bus.busy) b = 1;
            end
            check("abort_busy_seen", b, 1'b1);
        end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("abort_reset");
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        idx = 0;
        repeat (25) @(posedge clk);
        check("abort_no_valid", vcnt - v0, 0);
        check("abort_lfsr_idle", bus.lfsr_q, 8'h01);
        single_press_measure("after_abort");
        check("after_abort_lfsr", bus.lfsr_q, 8'h80);

        repeat (10) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
